// File: rtl/seg7_store_encoder.sv
// ----------------------------------------------------------------------------
// seg7_store_encoder
//
// Store-side seven-segment block for the LSU output-peripheral bank
// (byte region 0x0000_7020-0x0000_702F). Stored hex digits are encoded into
// active-low 7-segment patterns (bit6=g .. bit0=a) and held in per-digit
// registers. Loads return the raw stored pattern.
//
// Register map (offset within the region):
//   0x0-0x7 : digit registers 0..7
//   0x8     : CTRL, bit0 = scan enable, bit1 = blank-all
//   others  : reserved (writes ignored, reads return 0)
//
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_lsu_addr      LSU byte address
//   i_st_data       store data (bit4 = blank, bits3:0 = hex digit)
//   i_lsu_wren      store strobe, one cycle per store
//   o_ld_data       combinational load data for the addressed register
//   o_hex0..o_hex7  registered static segment patterns
//   o_scan_seg      registered pattern of the currently scanned digit
//   o_scan_an       registered active-low one-hot digit select
// ----------------------------------------------------------------------------
module seg7_store_encoder #(
    parameter int SCAN_DIV   = 50000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    output logic [31:0] o_ld_data,
    output logic [6:0]  o_hex0,
    output logic [6:0]  o_hex1,
    output logic [6:0]  o_hex2,
    output logic [6:0]  o_hex3,
    output logic [6:0]  o_hex4,
    output logic [6:0]  o_hex5,
    output logic [6:0]  o_hex6,
    output logic [6:0]  o_hex7,
    output logic [6:0]  o_scan_seg,
    output logic [7:0]  o_scan_an
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] BLANK = 7'h7F;

    logic            hit;
    logic            digit_sel;
    logic            ctrl_sel;
    logic [6:0]      digit [NUM_DIGITS];
    logic [1:0]      ctrl;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [6:0]      hex_q [NUM_DIGITS];
    logic            unused_data;

    // Upper store-data bits carry no meaning for this block.
    assign unused_data = ^i_st_data[31:5];

    assign hit       = (i_lsu_addr[31:4] == 28'h0000702);
    assign digit_sel = hit && !i_lsu_addr[3];
    assign ctrl_sel  = hit && i_lsu_addr[3] && (i_lsu_addr[2:0] == 3'd0);

    // Bit4 requests a blank digit; otherwise bits 3:0 select the glyph.
    function automatic logic [6:0] encode(input logic [4:0] v);
        logic [6:0] p;
        p = BLANK;
        if (!v[4]) begin
            case (v[3:0])
                4'h0: p = 7'h40;
                4'h1: p = 7'h79;
                4'h2: p = 7'h24;
                4'h3: p = 7'h30;
                4'h4: p = 7'h19;
                4'h5: p = 7'h12;
                4'h6: p = 7'h02;
                4'h7: p = 7'h78;
                4'h8: p = 7'h00;
                4'h9: p = 7'h10;
                4'hA: p = 7'h08;
                4'hB: p = 7'h03;
                4'hC: p = 7'h46;
                4'hD: p = 7'h21;
                4'hE: p = 7'h06;
                default: p = 7'h0E;
            endcase
        end
        return p;
    endfunction

    // Digit and control registers; reset takes priority over a store.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < NUM_DIGITS; n++) begin
                digit[n] <= BLANK;
            end
            ctrl <= 2'b00;
        end else if (i_lsu_wren) begin
            if (digit_sel) begin
                digit[i_lsu_addr[2:0]] <= encode(i_st_data[4:0]);
            end
            if (ctrl_sel) begin
                ctrl <= i_st_data[1:0];
            end
        end
    end

    // Scan prescaler and digit index; both held at 0 while scanning is off.
    always_ff @(posedge i_clk) begin
        if (i_rst || !ctrl[0]) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Output registers: one cycle behind the digit registers and index.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < NUM_DIGITS; n++) begin
                hex_q[n] <= BLANK;
            end
            o_scan_seg <= BLANK;
            o_scan_an  <= 8'hFF;
        end else begin
            for (int n = 0; n < NUM_DIGITS; n++) begin
                hex_q[n] <= ctrl[1] ? BLANK : digit[n];
            end
            o_scan_an  <= ctrl[0] ? ~(8'd1 << idx) : 8'hFF;
            o_scan_seg <= (ctrl[0] && !ctrl[1]) ? digit[idx] : BLANK;
        end
    end

    assign o_hex0 = hex_q[0];
    assign o_hex1 = hex_q[1];
    assign o_hex2 = hex_q[2];
    assign o_hex3 = hex_q[3];
    assign o_hex4 = hex_q[4];
    assign o_hex5 = hex_q[5];
    assign o_hex6 = hex_q[6];
    assign o_hex7 = hex_q[7];

    // Load path reads the registers directly, so a same-cycle store
    // to the same register still returns the old value.
    always_comb begin
        o_ld_data = 32'd0;
        if (digit_sel) begin
            o_ld_data = {25'd0, digit[i_lsu_addr[2:0]]};
        end else if (ctrl_sel) begin
            o_ld_data = {30'd0, ctrl};
        end
    end

endmodule

// File: tb/tb_seg7_store_encoder.sv
// ----------------------------------------------------------------------------
// tb_seg7_store_encoder
//
// Stimulus is driven 1 time unit after each rising edge. After every edge the
// reference model computes the outputs expected from that edge (plus the
// load data for the newly driven address) and pushes them into exp_q. A
// monitor on the falling edge pops each entry and compares it with the DUT.
// The scan position is modelled as (enabled cycles / SCAN_DIV) mod 8.
// ----------------------------------------------------------------------------
module tb_seg7_store_encoder;

  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst;
  logic [31:0] lsu_addr;
  logic [31:0] st_data;
  logic        lsu_wren;
  logic [31:0] ld_data;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [6:0]  scan_seg;
  logic [7:0]  scan_an;

  seg7_store_encoder #(.SCAN_DIV(SCAN_DIV), .NUM_DIGITS(8)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_lsu_addr (lsu_addr),
    .i_st_data  (st_data),
    .i_lsu_wren (lsu_wren),
    .o_ld_data  (ld_data),
    .o_hex0     (hex0),
    .o_hex1     (hex1),
    .o_hex2     (hex2),
    .o_hex3     (hex3),
    .o_hex4     (hex4),
    .o_hex5     (hex5),
    .o_hex6     (hex6),
    .o_hex7     (hex7),
    .o_scan_seg (scan_seg),
    .o_scan_an  (scan_an)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0][6:0] hex;
    logic [6:0]      seg;
    logic [7:0]      an;
    logic [31:0]     ld;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur_exp;
  logic [6:0] seg_tab [16];
  logic [6:0] m_dig [8];
  logic [1:0] m_ctrl;
  int         m_run;
  int         vectors;
  int         miscompares;

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int n = 0; n < 8; n++) m_dig[n] = 7'h7F;
    m_ctrl = 2'b00;
    m_run = 0;
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a[31:4] == 28'h0000702) begin
      if (!a[3]) r = {25'd0, m_dig[a[2:0]]};
      else if (a[2:0] == 3'd0) r = {30'd0, m_ctrl};
    end
    return r;
  endfunction

  // Outputs expected after the edge that just happened, from the register
  // contents that existed before it; then apply that edge's store.
  task automatic model_step(input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    int pos;
    if (r) begin
      for (int n = 0; n < 8; n++) cur_exp.hex[n] = 7'h7F;
      cur_exp.seg = 7'h7F;
      cur_exp.an  = 8'hFF;
      for (int n = 0; n < 8; n++) m_dig[n] = 7'h7F;
      m_ctrl = 2'b00;
      m_run = 0;
    end else begin
      pos = (m_run / SCAN_DIV) % 8;
      for (int n = 0; n < 8; n++) cur_exp.hex[n] = m_ctrl[1] ? 7'h7F : m_dig[n];
      cur_exp.an  = m_ctrl[0] ? ~(8'd1 << pos) : 8'hFF;
      cur_exp.seg = (m_ctrl[0] && !m_ctrl[1]) ? m_dig[pos] : 7'h7F;
      m_run = m_ctrl[0] ? m_run + 1 : 0;
      if (w && a[31:4] == 28'h0000702) begin
        if (!a[3]) m_dig[a[2:0]] = d[4] ? 7'h7F : seg_tab[d[3:0]];
        else if (a[2:0] == 3'd0) m_ctrl = d[1:0];
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    model_step(rst, lsu_wren, lsu_addr, st_data);
    #1;
    rst = r;
    lsu_wren = w;
    lsu_addr = a;
    st_data = d;
    cur_exp.ld = model_read(a);
    exp_q.push_back(cur_exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h7020 + 32'($urandom_range(0, 15)), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [7:0][6:0] hex_act;
  assign hex_act = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      for (int n = 0; n < 8; n++) begin
        if (hex_act[n] !== e.hex[n]) begin
          miscompares++;
          $display("FAIL hex%0d t=%0t act=%h exp=%h", n, $time, hex_act[n], e.hex[n]);
        end
      end
      if (scan_seg !== e.seg) begin
        miscompares++;
        $display("FAIL scan_seg t=%0t act=%h exp=%h", $time, scan_seg, e.seg);
      end
      if (scan_an !== e.an) begin
        miscompares++;
        $display("FAIL scan_an t=%0t act=%h exp=%h", $time, scan_an, e.an);
      end
      if (ld_data !== e.ld) begin
        miscompares++;
        $display("FAIL ld_data t=%0t addr=%h act=%h exp=%h", $time, lsu_addr, ld_data, e.ld);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] d;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    lsu_wren = 1'b0;
    lsu_addr = 32'h7020;
    st_data = 32'd0;

    // Reset for two cycles, then read digit 0.
    cycle(1'b1, 1'b0, 32'h7020, 32'd0);
    cycle(1'b0, 1'b0, 32'h7020, 32'd0);
    cycle(1'b0, 1'b0, 32'h7020, 32'd0);

    // Every hex digit through digit 0, with a readback after each store.
    for (int v = 0; v < 16; v++) begin
      cycle(1'b0, 1'b1, 32'h7020, 32'(v));
      cycle(1'b0, 1'b0, 32'h7020, 32'd0);
    end

    // Blank bit, ignored upper bits, reserved and out-of-region stores.
    cycle(1'b0, 1'b1, 32'h7023, 32'h13);
    cycle(1'b0, 1'b0, 32'h7023, 32'd0);
    cycle(1'b0, 1'b1, 32'h7023, 32'hFFFF_FFE7);
    cycle(1'b0, 1'b0, 32'h7023, 32'd0);
    cycle(1'b0, 1'b1, 32'h702C, 32'h5);
    cycle(1'b0, 1'b0, 32'h702C, 32'd0);
    cycle(1'b0, 1'b1, 32'h7030, 32'h5);
    cycle(1'b0, 1'b0, 32'h7030, 32'd0);
    cycle(1'b0, 1'b1, 32'h7029, 32'h3);
    cycle(1'b0, 1'b0, 32'h7028, 32'd0);
    cycle(1'b0, 1'b1, 32'h8020, 32'h1);
    idle(2);

    // Scan: digits 0..7 hold 0..7, enable, run past a full wrap.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 32'h7020 + 32'(i), 32'(i));
    cycle(1'b0, 1'b1, 32'h7028, 32'h1);
    idle(40);
    cycle(1'b0, 1'b1, 32'h7028, 32'h0);
    idle(3);
    cycle(1'b0, 1'b1, 32'h7028, 32'h1);
    idle(10);

    // Blank-all and restore.
    cycle(1'b0, 1'b1, 32'h7028, 32'h3);
    idle(6);
    cycle(1'b0, 1'b1, 32'h7028, 32'h1);
    idle(4);

    // Reset mid-scan with a coincident store.
    cycle(1'b0, 1'b1, 32'h7028, 32'h0);
    cycle(1'b0, 1'b1, 32'h7028, 32'h1);
    idle(21);
    cycle(1'b1, 1'b1, 32'h7021, 32'h3);
    cycle(1'b0, 1'b0, 32'h7021, 32'd0);
    idle(3);

    // Random traffic, mostly in-region, with occasional resets.
    cycle(1'b0, 1'b1, 32'h7028, 32'h1);
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 32'h7030 + 32'($urandom_range(0, 15))
                                       : 32'h7020 + 32'($urandom_range(0, 15));
      d = $urandom;
      if (a == 32'h7028 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, a, d);
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
